// File: rtl/heartbeat_pulse_gen_pkg.sv
// Shared constants for the heartbeat LED path: rate codes, FSM encoding, counter width.
// The state encoding puts the LED level in bit 0, so the LED can be driven straight from a flop.
package heartbeat_pulse_gen_pkg;

    localparam int unsigned CNT_W = 8;
    localparam int unsigned HB_W  = 2;

    localparam logic [HB_W-1:0] HB_FAST  = 2'd0;
    localparam logic [HB_W-1:0] HB_CALM  = 2'd1;
    localparam logic [HB_W-1:0] HB_SLOW  = 2'd2;
    localparam logic [HB_W-1:0] HB_SLEEP = 2'd3;

    // Bit 0 is set exactly in the pulse states (LUB, DUB).
    typedef enum logic [1:0] {
        REST = 2'b00,
        LUB  = 2'b01,
        GAP  = 2'b10,
        DUB  = 2'b11
    } state_t;

    typedef logic [CNT_W-1:0] cnt_t;
    typedef logic [HB_W-1:0]  hb_code_t;

    function automatic logic is_pulse(input state_t s);
        return s[0];
    endfunction

endpackage

// File: rtl/heartbeat_pulse_gen_if.sv
// Rate-code input and LED pulse outputs of the heartbeat pulse generator.
interface heartbeat_pulse_gen_if;
    import heartbeat_pulse_gen_pkg::*;

    logic     tick;
    hb_code_t heartbeat;
    logic     beat;
    logic     beat_strobe;
    hb_code_t hb_q;

    modport master (
        output tick,
        output heartbeat,
        input  beat,
        input  beat_strobe,
        input  hb_q
    );

    modport slave (
        input  tick,
        input  heartbeat,
        output beat,
        output beat_strobe,
        output hb_q
    );

endinterface

// File: rtl/heartbeat_period_lut.sv
// Maps a rate code to its beat period and returns the REST-state counter load
// (period minus the lub/gap/dub ticks and the single REST tick that ends at cnt==0).
module heartbeat_period_lut
    import heartbeat_pulse_gen_pkg::*;
#(
    parameter int unsigned PULSE_LEN = 3,
    parameter int unsigned GAP_LEN   = 2,
    parameter int unsigned PERIOD_0  = 20,
    parameter int unsigned PERIOD_1  = 40,
    parameter int unsigned PERIOD_2  = 60,
    parameter int unsigned PERIOD_3  = 100
) (
    input  hb_code_t code,
    output cnt_t     rest_load
);

    localparam int unsigned MIN_PERIOD = 2 * PULSE_LEN + GAP_LEN + 1;
    localparam int unsigned MAX_PERIOD = 255;

    if (PULSE_LEN < 1 || PULSE_LEN > 15) begin : g_bad_pulse_len
        $error("heartbeat_period_lut: PULSE_LEN must be within 1..15");
    end
    if (GAP_LEN < 1 || GAP_LEN > 15) begin : g_bad_gap_len
        $error("heartbeat_period_lut: GAP_LEN must be within 1..15");
    end
    if (PERIOD_0 < MIN_PERIOD || PERIOD_0 > MAX_PERIOD) begin : g_bad_period_0
        $error("heartbeat_period_lut: PERIOD_0 out of range");
    end
    if (PERIOD_1 < MIN_PERIOD || PERIOD_1 > MAX_PERIOD) begin : g_bad_period_1
        $error("heartbeat_period_lut: PERIOD_1 out of range");
    end
    if (PERIOD_2 < MIN_PERIOD || PERIOD_2 > MAX_PERIOD) begin : g_bad_period_2
        $error("heartbeat_period_lut: PERIOD_2 out of range");
    end
    if (PERIOD_3 < MIN_PERIOD || PERIOD_3 > MAX_PERIOD) begin : g_bad_period_3
        $error("heartbeat_period_lut: PERIOD_3 out of range");
    end

    cnt_t period;

    always_comb begin
        period = CNT_W'(PERIOD_3);
        case (code)
            HB_FAST:  period = CNT_W'(PERIOD_0);
            HB_CALM:  period = CNT_W'(PERIOD_1);
            HB_SLOW:  period = CNT_W'(PERIOD_2);
            HB_SLEEP: period = CNT_W'(PERIOD_3);
            default:  period = CNT_W'(PERIOD_3);
        endcase
    end

    // Cannot underflow: every period is at least MIN_PERIOD.
    assign rest_load = period - CNT_W'(MIN_PERIOD);

endmodule

// File: rtl/heartbeat_pulse_gen.sv
// Turns the heartbeat rate code into a lub-dub LED pulse train paced by the prescaler tick.
// The rate code is captured once per beat, so a beat in progress always completes at its own rate.
module heartbeat_pulse_gen
    import heartbeat_pulse_gen_pkg::*;
#(
    parameter int unsigned PULSE_LEN = 3,
    parameter int unsigned GAP_LEN   = 2,
    parameter int unsigned PERIOD_0  = 20,
    parameter int unsigned PERIOD_1  = 40,
    parameter int unsigned PERIOD_2  = 60,
    parameter int unsigned PERIOD_3  = 100
) (
    input logic                  clk,
    input logic                  rst,
    heartbeat_pulse_gen_if.slave hb_bus
);

    state_t   state;
    state_t   state_nxt;
    cnt_t     cnt;
    cnt_t     cnt_nxt;
    hb_code_t hb_q;
    hb_code_t hb_q_nxt;
    logic     strobe;
    logic     strobe_nxt;
    cnt_t     rest_load;
    logic     cnt_done;

    heartbeat_period_lut #(
        .PULSE_LEN (PULSE_LEN),
        .GAP_LEN   (GAP_LEN),
        .PERIOD_0  (PERIOD_0),
        .PERIOD_1  (PERIOD_1),
        .PERIOD_2  (PERIOD_2),
        .PERIOD_3  (PERIOD_3)
    ) u_period_lut (
        .code      (hb_q),
        .rest_load (rest_load)
    );

    assign cnt_done = (cnt == '0);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= REST;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: a state ends on the tick that finds its counter at zero
    always_comb begin
        state_nxt = state;
        if (hb_bus.tick && cnt_done) begin
            case (state)
                REST:    state_nxt = LUB;
                LUB:     state_nxt = GAP;
                GAP:     state_nxt = DUB;
                DUB:     state_nxt = REST;
                default: state_nxt = REST;
            endcase
        end
    end

    // Counter loads, rate-code capture and beat-start strobe
    always_comb begin
        cnt_nxt    = cnt;
        hb_q_nxt   = hb_q;
        strobe_nxt = 1'b0;
        if (hb_bus.tick) begin
            if (!cnt_done) begin
                cnt_nxt = cnt - CNT_W'(1);
            end else begin
                case (state)
                    REST: begin
                        hb_q_nxt   = hb_bus.heartbeat;
                        cnt_nxt    = CNT_W'(PULSE_LEN - 1);
                        strobe_nxt = 1'b1;
                    end
                    LUB:     cnt_nxt = CNT_W'(GAP_LEN - 1);
                    GAP:     cnt_nxt = CNT_W'(PULSE_LEN - 1);
                    DUB:     cnt_nxt = rest_load;
                    default: cnt_nxt = '0;
                endcase
            end
        end
    end

    // Datapath and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt    <= '0;
            hb_q   <= HB_SLEEP;
            strobe <= 1'b0;
        end else begin
            cnt    <= cnt_nxt;
            hb_q   <= hb_q_nxt;
            strobe <= strobe_nxt;
        end
    end

    assign hb_bus.beat        = is_pulse(state);
    assign hb_bus.beat_strobe = strobe;
    assign hb_bus.hb_q        = hb_q;

endmodule

// File: tb/tb_heartbeat_pulse_gen.sv
// Directed bench for heartbeat_pulse_gen: default instance plus a minimum-period instance.
module tb_heartbeat_pulse_gen;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    heartbeat_pulse_gen_if bus ();
    heartbeat_pulse_gen_if bus_min ();

    heartbeat_pulse_gen dut (
        .clk    (clk),
        .rst    (rst),
        .hb_bus (bus.slave)
    );

    heartbeat_pulse_gen #(
        .PERIOD_0 (9)
    ) dut_min (
        .clk    (clk),
        .rst    (rst),
        .hb_bus (bus_min.slave)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Defaults: lub over beat positions 0..2, gap 3..4, dub 5..7, rest afterwards.
    function automatic logic exp_beat(input int p);
        return (p < 3) || (p >= 5 && p < 8);
    endfunction

    task automatic cyc(input logic t, input logic t_min);
        @(negedge clk);
        bus.tick     = t;
        bus_min.tick = t_min;
        @(posedge clk);
        #1;
    endtask

    task automatic tick_chk(input string tag, input int p);
        cyc(1'b1, 1'b0);
        check($sformatf("%s_beat_p%0d", tag, p), 32'(bus.beat), 32'(exp_beat(p)));
        check($sformatf("%s_strobe_p%0d", tag, p), 32'(bus.beat_strobe), 32'(p == 0));
    endtask

    initial begin
        rst               = 1'b1;
        bus.tick          = 1'b0;
        bus.heartbeat     = 2'd1;
        bus_min.tick      = 1'b0;
        bus_min.heartbeat = 2'd0;

        cyc(1'b0, 1'b0);
        cyc(1'b0, 1'b0);
        check("reset_beat", 32'(bus.beat), 32'd0);
        check("reset_strobe", 32'(bus.beat_strobe), 32'd0);
        check("reset_hb_q", 32'(bus.hb_q), 32'd3);
        check("reset_min_hb_q", 32'(bus_min.hb_q), 32'd3);

        rst = 1'b0;
        cyc(1'b0, 1'b0);
        cyc(1'b0, 1'b0);
        check("idle_beat", 32'(bus.beat), 32'd0);
        check("idle_strobe", 32'(bus.beat_strobe), 32'd0);

        // Continuous tick, code 1: two full 40-tick beats
        for (int b = 0; b < 2; b++) begin
            for (int p = 0; p < 40; p++) begin
                tick_chk("calm", p);
                if (p == 0) check("calm_hb_q", 32'(bus.hb_q), 32'd1);
            end
        end

        // Code switches to 0 during the dub pulse; current beat keeps 40 ticks
        for (int p = 0; p < 40; p++) begin
            if (p == 6) bus.heartbeat = 2'd0;
            tick_chk("switch", p);
            if (p == 39) check("switch_hb_q_held", 32'(bus.hb_q), 32'd1);
        end
        for (int b = 0; b < 2; b++) begin
            for (int p = 0; p < 20; p++) begin
                tick_chk("fast", p);
                if (b == 0 && p == 0) check("fast_hb_q", 32'(bus.hb_q), 32'd0);
            end
        end

        // Tick every 4th cycle, code 3: 400-cycle beat, strobe one clk wide
        bus.heartbeat = 2'd3;
        for (int p = 0; p < 100; p++) begin
            tick_chk("slow", p);
            if (p == 0) check("slow_hb_q", 32'(bus.hb_q), 32'd3);
            for (int k = 0; k < 3; k++) begin
                cyc(1'b0, 1'b0);
                check($sformatf("slow_hold_beat_p%0d", p), 32'(bus.beat), 32'(exp_beat(p)));
                check($sformatf("slow_hold_strobe_p%0d", p), 32'(bus.beat_strobe), 32'd0);
            end
        end
        tick_chk("slow_next", 0);

        // Reset during LUB with tick high
        bus.heartbeat = 2'd1;
        tick_chk("pre_rst", 1);
        rst = 1'b1;
        cyc(1'b1, 1'b0);
        check("rst_lub_beat", 32'(bus.beat), 32'd0);
        check("rst_lub_strobe", 32'(bus.beat_strobe), 32'd0);
        check("rst_lub_hb_q", 32'(bus.hb_q), 32'd3);
        rst = 1'b0;
        cyc(1'b0, 1'b0);
        check("post_rst_beat", 32'(bus.beat), 32'd0);
        for (int p = 0; p < 40; p++) begin
            tick_chk("restart", p);
            if (p == 0) check("restart_hb_q", 32'(bus.hb_q), 32'd1);
        end

        // Ticks paused for 50 cycles mid-GAP
        for (int p = 0; p < 40; p++) begin
            tick_chk("gap", p);
            if (p == 3) begin
                for (int k = 0; k < 50; k++) begin
                    cyc(1'b0, 1'b0);
                    check("gap_freeze_beat", 32'(bus.beat), 32'd0);
                    check("gap_freeze_strobe", 32'(bus.beat_strobe), 32'd0);
                end
            end
        end

        // Minimum period 9: REST lasts one tick, beats back to back
        check("min_pre_hb_q", 32'(bus_min.hb_q), 32'd3);
        for (int b = 0; b < 3; b++) begin
            for (int p = 0; p < 9; p++) begin
                cyc(1'b0, 1'b1);
                check($sformatf("min_beat_b%0d_p%0d", b, p), 32'(bus_min.beat), 32'(exp_beat(p)));
                check($sformatf("min_strobe_b%0d_p%0d", b, p), 32'(bus_min.beat_strobe), 32'(p == 0));
                if (b == 0 && p == 0) check("min_hb_q", 32'(bus_min.hb_q), 32'd0);
            end
        end
        check("min_idle_other_beat", 32'(bus.beat), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
